// File: rtl/chunk_subtractor.sv
// -----------------------------------------------------------------------------
// chunk_subtractor
//   Multi-cycle N-bit subtractor computing D = A - B - Bin (mod 2^N) using one
//   W-bit subtract per cycle over K = N/W chunks, least significant chunk
//   first. Operands are taken on an in_valid/in_ready handshake. The result
//   is held on an out_valid/out_ready handshake.
//   N must be an integer multiple of W. K = 1 (W = N) is legal.
//
//   Latency: out_valid rises exactly K+1 clk edges after the accepting edge.
//   These are K RUN edges plus one DONE edge that publishes out_valid.
//
// Optional feature (macro CHUNK_SUB_OVF_EN): adds output V. V is the signed
//   overflow flag: sign(A) != sign(B) and sign(D) != sign(A).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  block accepts operands (IDLE only)
//   A, B       in   N-bit minuend / subtrahend
//   Bin        in   borrow-in
//   out_valid  out  result present (DONE only)
//   out_ready  in   consumer accepts result
//   D          out  N-bit difference
//   Bout       out  borrow-out (A < B + Bin, unsigned)
//   Z          out  D == 0
//   V          out  signed overflow (only with CHUNK_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module chunk_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         Z
`ifdef CHUNK_SUB_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int K  = N / W;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          borrow_q, borrow_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  d_q, d_d;
    logic          bout_q, bout_d;
    logic          z_q, z_d;
    logic          valid_q, valid_d;
    // Low through reset and for the cycle it releases; keeps in_ready at 0
    // until the first edge after rst_n deasserts.
    logic          live_q;
    logic [W:0]    chunk_diff;

`ifdef CHUNK_SUB_OVF_EN
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic          v_q, v_d;
`endif

    // The operand registers shift right by W every RUN cycle. The current
    // chunk is therefore always in the low W bits. The extra top bit of the
    // (W+1)-bit subtract is the chunk borrow.
    assign chunk_diff = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, borrow_q};

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        bout_d   = bout_q;
        z_d      = z_q;
        valid_d  = valid_q;
`ifdef CHUNK_SUB_OVF_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        v_d      = v_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    k_d      = '0;
                    state_d  = RUN;
`ifdef CHUNK_SUB_OVF_EN
                    sign_a_d = A[N-1];
                    sign_b_d = B[N-1];
`endif
                end
            end
            RUN: begin
                d_d[k_q*W +: W] = chunk_diff[W-1:0];
                borrow_d        = chunk_diff[W];
                a_d             = a_q >> W;
                b_d             = b_q >> W;
                k_d             = k_q + 1'b1;
                if (k_q == KW'(K - 1)) begin
                    k_d     = '0;
                    bout_d  = chunk_diff[W];
                    z_d     = (d_d == '0);
                    state_d = DONE;
`ifdef CHUNK_SUB_OVF_EN
                    // The last chunk's top bit is the sign of D.
                    v_d = (sign_a_q != sign_b_q) && (chunk_diff[W-1] != sign_a_q);
`endif
                end
            end
            DONE: begin
                // The first DONE cycle only raises out_valid. This is where the
                // extra latency edge comes from.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            z_q      <= 1'b1;
            valid_q  <= 1'b0;
            live_q   <= 1'b0;
`ifdef CHUNK_SUB_OVF_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            z_q      <= z_d;
            valid_q  <= valid_d;
            live_q   <= 1'b1;
`ifdef CHUNK_SUB_OVF_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            v_q      <= v_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && live_q;
    assign out_valid = valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
    assign Z         = z_q;
`ifdef CHUNK_SUB_OVF_EN
    assign V         = v_q;
`endif

endmodule

// File: tb/tb_chunk_subtractor.sv
// -----------------------------------------------------------------------------
// tb_chunk_subtractor
//   Self-checking bench for chunk_subtractor (N=32, W=8).
//
//   The reference model takes each accepted transaction. It computes the
//   answer with a single wide subtraction, and counts K+1 edges to know when
//   the result must appear. A negedge compare process checks the handshake
//   outputs every cycle, and checks the result whenever it is defined. Directed
//   transactions pin literal expected values. A randomized phase then covers
//   the remainder of the operand space.
//   Build with +define+CHUNK_SUB_OVF_EN to also check V.
// -----------------------------------------------------------------------------
module tb_chunk_subtractor;

    localparam int N = 32;
    localparam int W = 8;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] D;
    logic         Bout;
    logic         Z;
`ifdef CHUNK_SUB_OVF_EN
    logic         V;
`endif

    chunk_subtractor #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .Z         (Z)
`ifdef CHUNK_SUB_OVF_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_busy   = 1'b0;
    logic         m_valid  = 1'b0;
    logic         m_rdy_ok = 1'b0;
    int           m_cnt    = 0;
    logic [N-1:0] m_d      = '0;
    logic         m_bout   = 1'b0;
    logic         m_z      = 1'b1;
    logic         m_v      = 1'b0;
    logic [N-1:0] p_d;
    logic         p_bout;
    logic         p_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_valid  = 1'b0;
            m_rdy_ok = 1'b0;
            m_cnt    = 0;
            m_d      = '0;
            m_bout   = 1'b0;
            m_z      = 1'b1;
            m_v      = 1'b0;
        end else begin
            if (!m_busy) begin
                if (m_rdy_ok && in_valid) begin
                    {p_bout, p_d} = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, Bin};
                    p_v    = (A[N-1] != B[N-1]) && (p_d[N-1] != A[N-1]);
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else if (m_valid) begin
                if (out_ready) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b0;
                    n_done++;
                end
            end else begin
                m_cnt++;
                if (m_cnt == K + 1) begin
                    m_valid = 1'b1;
                    m_d     = p_d;
                    m_bout  = p_bout;
                    m_z     = (p_d == '0);
                    m_v     = p_v;
                end
            end
            m_rdy_ok = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("in_ready", in_ready, m_rdy_ok && !m_busy);
        check("out_valid", out_valid, m_valid);
        if (m_valid || !m_busy) begin
            check("D", D, m_d);
            check("Bout", Bout, m_bout);
            check("Z", Z, m_z);
`ifdef CHUNK_SUB_OVF_EN
            check("V", V, m_v);
`endif
        end
    end

    // ---------------- directed transaction ----------------
    task automatic txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input int hold, input logic [N-1:0] ed, input logic eb, input logic ez);
        int lat;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("wait_in_ready", in_ready, 1'b1);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; A = $urandom; B = $urandom; Bin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, K + 1);
        check("D_lit", D, ed);
        check("Bout_lit", Bout, eb);
        check("Z_lit", Z, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; A = $urandom; B = $urandom;
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_D", D, ed);
            check("stall_Bout", Bout, eb);
            check("stall_Z", Z, ez);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", in_ready, 1'b1);
        check("post_hs_out_valid", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_D", D, 32'h0);
        check("rst_Z", Z, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);

        txn(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 32'h0000_0002, 1'b0, 1'b0);
        txn(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        txn(32'h0000_0100, 32'h0000_0000, 1'b1, 0, 32'h0000_00FF, 1'b0, 1'b0);
        txn(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b1);
        txn(32'h0000_0005, 32'h0000_0003, 1'b0, 3, 32'h0000_0002, 1'b0, 1'b0);
`ifdef CHUNK_SUB_OVF_EN
        txn(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 32'h7FFF_FFFF, 1'b0, 1'b0);
        check("V_lit", V, 1'b1);
`endif

        // Reset while the third chunk (k=2) is being processed.
        @(negedge clk);
        A = 32'hDEAD_BEEF; B = 32'h0123_4567; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", out_valid, 1'b0);
        check("midrun_rst_D", D, 32'h0);
        check("midrun_rst_Z", Z, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        txn(32'd9, 32'd4, 1'b0, 0, 32'd5, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            A         = pick();
            B         = pick();
            Bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (K + 4) @(negedge clk);
        check("enough_transactions", (n_done > 50), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
